// File: rtl/cfg_frame_scheduler_pkg.sv
// Shared types and constants for the configuration frame scheduler.
// Build option: CFG_CHECKSUM_EN selects the 5-byte frame with an XOR checksum byte.
package cfg_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PENDING
  } state_t;

`ifdef CFG_CHECKSUM_EN
  localparam int unsigned CFG_FRAME_BYTES = 5;
`else
  localparam int unsigned CFG_FRAME_BYTES = 4;
`endif

  localparam logic [31:0] CFG_DEFAULT = 32'hBBFC_0000;

  // Mode-select fields of the committed configuration word
  localparam int unsigned CFG_MODE_MSB = 31;
  localparam int unsigned CFG_MODE_LSB = 30;
  localparam int unsigned CFG_SEL_MSB  = 29;
  localparam int unsigned CFG_SEL_LSB  = 24;

endpackage

// File: rtl/cfg_shift_collector.sv
// Byte counter, MSB-first shadow word and (with CFG_CHECKSUM_EN) XOR accumulator.
module cfg_shift_collector
  import cfg_frame_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_shift,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [2:0]  o_count,
`ifdef CFG_CHECKSUM_EN
  output logic [7:0]  o_csum,
`endif
  output logic [31:0] o_shadow
);

  logic [2:0]  r_count;
  logic [31:0] r_shadow;

  // Bytes beyond the fourth (the checksum byte) only advance the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_shadow <= '0;
    end else if (i_clear) begin
      r_count  <= '0;
      r_shadow <= '0;
    end else if (i_start) begin
      r_count  <= 3'd1;
      r_shadow <= {i_byte, 24'h00_0000};
    end else if (i_shift) begin
      r_count <= r_count + 3'd1;
      case (r_count)
        3'd1:    r_shadow[23:16] <= i_byte;
        3'd2:    r_shadow[15:8]  <= i_byte;
        3'd3:    r_shadow[7:0]   <= i_byte;
        default: ;
      endcase
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_csum <= '0;
    else if (i_clear) r_csum <= '0;
    else if (i_start) r_csum <= i_byte;
    else if (i_shift) r_csum <= r_csum ^ i_byte;
  end

  assign o_csum = r_csum;
`endif

  assign o_count  = r_count;
  assign o_shadow = r_shadow;

endmodule

// File: rtl/cfg_frame_scheduler.sv
// Collects SPI configuration frames and commits them at vertical blank.
// Build option: CFG_CHECKSUM_EN adds a fifth XOR checksum byte per frame.
module cfg_frame_scheduler
  import cfg_frame_scheduler_pkg::*;
#(
  parameter logic [31:0] RESET_CFG = CFG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        ss,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        vblank_start,
  output logic [31:0] configuration,
  output logic        cfg_commit,
  output logic        cfg_pending,
  output logic        cfg_error
);

  localparam logic [2:0] LAST_IDX = 3'(CFG_FRAME_BYTES - 1);

  state_t      r_state;
  logic        r_ss_q;
  logic [31:0] r_cfg;
  logic        r_commit;
  logic        r_pending;
  logic        r_error;

  logic        w_ss_rise;
  logic        w_byte_lo;
  logic        w_take;
  logic        w_last;
  logic        w_frame_ok;
  logic        w_start;
  logic        w_shift;
  logic        w_clear;
  logic [2:0]  w_count;
  logic [31:0] w_shadow;

  assign w_ss_rise = ss & ~r_ss_q;
  assign w_byte_lo = byte_valid & ~ss;
  // A byte arriving with the ss rise still belongs to the frame
  assign w_take    = byte_valid & (~ss | w_ss_rise);
  assign w_last    = w_take & (w_count == LAST_IDX);

`ifdef CFG_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_frame_ok = (byte_data == w_csum);
`else
  assign w_frame_ok = 1'b1;
`endif

  cfg_shift_collector u_collector (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_clear  (w_clear),
    .i_byte   (byte_data),
    .o_count  (w_count),
`ifdef CFG_CHECKSUM_EN
    .o_csum   (w_csum),
`endif
    .o_shadow (w_shadow)
  );

  always_comb begin
    w_start = 1'b0;
    w_shift = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE:    w_start = w_byte_lo;
      ST_COLLECT: begin
        w_shift = w_take;
        if (w_last)         w_clear = ~w_frame_ok;
        else if (w_ss_rise) w_clear = 1'b1;
      end
      ST_PENDING: w_start = w_byte_lo;
      default:    w_clear = 1'b1;
    endcase
  end

  // A new byte in PENDING wins over a coincident vblank: the old word is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ss_q    <= 1'b1;
      r_cfg     <= RESET_CFG;
      r_commit  <= 1'b0;
      r_pending <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_ss_q   <= ss;
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_byte_lo) r_state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (w_last) begin
            if (w_frame_ok) begin
              r_state   <= ST_PENDING;
              r_pending <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_error <= 1'b1;
            end
          end else if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_error <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_byte_lo) begin
            r_state   <= ST_COLLECT;
            r_pending <= 1'b0;
          end else if (vblank_start && ena) begin
            r_state   <= ST_IDLE;
            r_cfg     <= w_shadow;
            r_commit  <= 1'b1;
            r_pending <= 1'b0;
            r_error   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign configuration = r_cfg;
  assign cfg_commit    = r_commit;
  assign cfg_pending   = r_pending;
  assign cfg_error     = r_error;

endmodule

// File: tb/tb_cfg_frame_scheduler.sv
// Self-checking bench for cfg_frame_scheduler: queue-based frame model plus directed cases.
module tb_cfg_frame_scheduler;

`ifdef CFG_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        ss;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        vblank_start;
  logic [31:0] configuration;
  logic        cfg_commit;
  logic        cfg_pending;
  logic        cfg_error;

  int n_tests = 0;
  int n_fail  = 0;

  cfg_frame_scheduler #(.RESET_CFG(32'hBBFC_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .ss            (ss),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .vblank_start  (vblank_start),
    .configuration (configuration),
    .cfg_commit    (cfg_commit),
    .cfg_pending   (cfg_pending),
    .cfg_error     (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a queue of bytes; a complete frame becomes the pending word.
  logic [7:0]  fq[$];
  bit          m_pend;
  logic [31:0] m_word;
  logic [31:0] m_cfg;
  bit          m_commit;
  bit          m_err;
  bit          m_prev_ss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      m_pend = 0; m_word = '0; m_cfg = 32'hBBFC_0000;
      m_commit = 0; m_err = 0; m_prev_ss = 1;
    end else begin : step
      bit rise;
      bit ok;
      rise = ss && !m_prev_ss;
      m_prev_ss = ss;
      m_commit = 0;
      if (m_pend) begin
        if (byte_valid && !ss) begin
          m_pend = 0;
          fq.delete();
          fq.push_back(byte_data);
        end else if (vblank_start && ena) begin
          m_cfg = m_word; m_commit = 1; m_pend = 0; m_err = 0;
        end
      end else if (fq.size() > 0) begin
        if (byte_valid && (!ss || rise)) fq.push_back(byte_data);
        if (fq.size() == NB) begin
`ifdef CFG_CHECKSUM_EN
          ok = (fq[4] == (fq[0] ^ fq[1] ^ fq[2] ^ fq[3]));
`else
          ok = 1;
`endif
          if (ok) begin
            m_word = {fq[0], fq[1], fq[2], fq[3]};
            m_pend = 1;
          end else m_err = 1;
          fq.delete();
        end else if (rise) begin
          m_err = 1;
          fq.delete();
        end
      end else if (byte_valid && !ss) begin
        fq.push_back(byte_data);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk32("model.configuration", configuration, m_cfg);
    chk1("model.cfg_commit", cfg_commit, m_commit);
    chk1("model.cfg_pending", cfg_pending, m_pend);
    chk1("model.cfg_error", cfg_error, m_err);
  end

  task automatic drive(input logic s, input logic bv, input logic [7:0] d,
                       input logic vb, input logic en);
    ss = s; byte_valid = bv; byte_data = d; vblank_start = vb; ena = en;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic vblank();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Sends one frame with ss low; last_vb puts vblank_start on the final byte.
  task automatic send_word(input logic [31:0] w, input bit last_vb);
    logic [7:0] b;
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < 4) b = w[31 - 8*i -: 8];
      else       b = x;
      x = x ^ b;
      drive(1'b0, 1'b1, b, logic'(last_vb && (i == NB - 1)), 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; ss = 1'b1; byte_valid = 1'b0; byte_data = '0;
    vblank_start = 1'b0; ena = 1'b1;
    repeat (3) @(negedge clk);
    chk32("reset.configuration", configuration, 32'hBBFC_0000);
    chk1("reset.commit", cfg_commit, 1'b0);
    chk1("reset.pending", cfg_pending, 1'b0);
    chk1("reset.error", cfg_error, 1'b0);
    rst_n = 1'b1;

    // good frame
    send_word(32'h1234_5678, 0); idle();
    chk1("good.pending", cfg_pending, 1'b1);
    chk32("good.cfg_before", configuration, 32'hBBFC_0000);
    vblank();
    chk32("good.cfg_after", configuration, 32'h1234_5678);
    chk1("good.commit", cfg_commit, 1'b1);
    chk1("good.pending_clr", cfg_pending, 1'b0);
    idle();
    chk1("good.commit_1cyc", cfg_commit, 1'b0);

    // abort after two bytes
    drive(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
    idle();
    chk1("abort.error", cfg_error, 1'b1);
    chk1("abort.pending", cfg_pending, 1'b0);
    vblank();
    chk1("abort.no_commit", cfg_commit, 1'b0);
    chk32("abort.cfg", configuration, 32'h1234_5678);

    // overwrite: A pending, B replaces it
    send_word(32'h1122_3344, 0); idle();
    chk1("ovw.pendA", cfg_pending, 1'b1);
    send_word(32'h5566_7788, 0); idle();
    chk1("ovw.pendB", cfg_pending, 1'b1);
    vblank();
    chk32("ovw.cfg", configuration, 32'h5566_7788);
    chk1("ovw.commit", cfg_commit, 1'b1);
    chk1("ovw.err_clr", cfg_error, 1'b0);
    idle();
    chk1("ovw.commit_1cyc", cfg_commit, 1'b0);
    vblank();
    chk1("ovw.single_commit", cfg_commit, 1'b0);

    // word completing on the vblank cycle waits for the next vblank
    send_word(32'h9ABC_DEF0, 1);
    chk1("same.pending", cfg_pending, 1'b1);
    chk1("same.no_commit", cfg_commit, 1'b0);
    chk32("same.cfg_held", configuration, 32'h5566_7788);
    idle(); vblank();
    chk32("same.cfg", configuration, 32'h9ABC_DEF0);
    chk1("same.commit", cfg_commit, 1'b1);

    // ena low holds the pending word
    send_word(32'h0F1E_2D3C, 0); idle();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk1("ena.no_commit", cfg_commit, 1'b0);
    chk1("ena.pending", cfg_pending, 1'b1);
    repeat (5) idle();
    chk1("ena.hold", cfg_pending, 1'b1);
    chk32("ena.cfg_held", configuration, 32'h9ABC_DEF0);
    vblank();
    chk32("ena.cfg", configuration, 32'h0F1E_2D3C);
    chk1("ena.commit", cfg_commit, 1'b1);

`ifdef CFG_CHECKSUM_EN
    drive(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle();
    chk1("csum.pending", cfg_pending, 1'b1);
    vblank();
    chk32("csum.cfg", configuration, 32'hAA55_00FF);
    drive(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    idle();
    chk1("csum.bad_error", cfg_error, 1'b1);
    chk1("csum.bad_pending", cfg_pending, 1'b0);
`endif

    // randomized traffic against the model
    begin
      logic rs;
      logic [7:0] rd;
      rs = 1'b1;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(7) == 0) rs = ~rs;
        rd = 8'($urandom);
`ifdef CFG_CHECKSUM_EN
        if (fq.size() == 4 && $urandom_range(3) != 0) rd = fq[0] ^ fq[1] ^ fq[2] ^ fq[3];
`endif
        drive(rs, logic'($urandom_range(1)), rd,
              logic'($urandom_range(15) == 0), logic'($urandom_range(3) != 0));
      end
    end
    idle();

    // reset mid-frame and with a word pending
    send_word(32'h4455_6677, 0); idle(); vblank();
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk32("rst_mid.cfg", configuration, 32'hBBFC_0000);
    chk1("rst_mid.error", cfg_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send_word(32'h0102_0304, 0); idle();
    rst_n = 1'b0;
    #1;
    chk1("rst_pend.pending", cfg_pending, 1'b0);
    @(negedge clk);
    vblank();
    chk1("rst_pend.no_commit", cfg_commit, 1'b0);
    rst_n = 1'b1;
    // first byte lands on the first edge after reset release
    send_word(32'hCAFE_F00D, 0); idle(); vblank();
    chk32("post_rst.cfg", configuration, 32'hCAFE_F00D);
    chk1("post_rst.commit", cfg_commit, 1'b1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
